reorder_ctrl: RTL and testbench
===============================

# reorder_ctrl

Ping-pong bank scheduler for the FFT output reorder stage. It accepts two samples per cycle from the last butterfly stage and generates write addresses into a two-bank, two-lane sample memory. It then issues one read per cycle in bit-reversed order to serialise a complete frame. The block owns only control: addresses, enables, bank status, flow control and frame markers. Sample data lives in the reorder memory alongside it.

## Interface
- FFT_LENGTH, 16, samples per frame N; power of two, ≥4
- ADDR_WIDTH, $clog2(FFT_LENGTH), sample-index width; lane address width is ADDR_WIDTH-1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents sample pair (2k, 2k+1)
- in_ready  out  1  write bank is free; pair is accepted when in_valid&in_ready
- wr_en  out  1  write both lanes this cycle (combinational: in_valid&in_ready)
- wr_bank  out  1  bank being filled
- wr_addr  out  ADDR_WIDTH-1  pair index k
- rd_en  out  1  read request this cycle
- rd_bank  out  1  bank being drained
- rd_lane  out  1  lane of the read sample (bit 0 of sample index)
- rd_addr  out  ADDR_WIDTH-1  lane address (sample index >> 1)
- out_valid  out  1  memory read data valid (rd_en delayed 1 cycle)
- out_last  out  1  with out_valid, last sample of the frame
- ovf_err  out  1  sticky; in_valid seen while in_ready=0

## Operation
- Per-bank status bit full[1:0]; reset 0 (both free).
- Write side: wr_cnt counts accepted pairs 0..N/2-1. When the accept occurs with wr_cnt=N/2-1: set full[wr_bank], toggle wr_bank, clear wr_cnt.
- in_ready = !full[wr_bank], derived from registers only.
- Read side FSM:
  - IDLE→READ when full[rd_bank]=1.
  - READ: rd_en=1 and rd_cnt increments 0..N-1. Sample index s = bitrev(rd_cnt) over ADDR_WIDTH bits; rd_lane=s[0], rd_addr=s>>1.
  - At rd_cnt=N-1: clear full[rd_bank] and toggle rd_bank. Stay in READ if the other bank is already full (no bubble); otherwise go to IDLE.
- Simultaneous set and clear always target different banks. Both are applied on the same edge.
- Dropped pair (in_valid&!in_ready): no write, no counter change, ovf_err←1 until reset.
- Steady-state input duty ≤50% (N/2 write cycles vs N read cycles). Upstream must honour in_ready.

## Timing
- Reset values:
  - in_ready=1.
  - wr_en=0 (in_valid=0), wr_bank=0, wr_addr=0.
  - rd_en=0, rd_bank=0, rd_lane=0, rd_addr=0.
  - out_valid=0, out_last=0, ovf_err=0.
- Last pair accepted at edge t: full visible at t+1, first rd_en in cycle t+1, first out_valid in cycle t+2.
- out_valid/out_last are rd_en/(rd_cnt==N-1) registered once.
- Bank freed at edge t: in_ready for that bank rises in cycle t+1 (if it is the write bank).
- Reset mid-frame: counters, status, FSM and outputs return to reset values immediately. The partial frame is discarded and no further out_valid is produced for it.

## Configuration
- REORDER_BITREV_EN defined: read order is bit-reversed as above (radix-2 DIF output to natural order).
- Undefined: s = rd_cnt (natural order; the block is a plain 2:1 serialiser). All other timing is unchanged.

## Structure
- Shared package reorder_pkg: read FSM state enum (IDLE, READ), function bitrev(value, width), and a localparam for the lane address width.
- One sub-module, reorder_rd_seq: rd_cnt, bit-reversal and lane/address split, with a done pulse back to the controller.

## Test plan
- Single frame, N=16: 8 consecutive accepts → wr_addr 0..7 on bank 0. rd_en runs for 16 cycles starting the cycle after the 8th accept. (rd_lane, rd_addr) sequence: (0,0),(0,4),(0,2),(0,6),(0,1),(0,5),(0,3),(0,7),(1,0),(1,4),(1,2),(1,6),(1,1),(1,5),(1,3),(1,7). out_last is asserted on the 16th out_valid.
- Back-to-back frames: 16 accepts offered as fast as in_ready allows → bank 1 fills while bank 0 drains. 32 contiguous rd_en cycles with no gap; rd_bank flips at cycle 16.
- Overflow: hold in_valid=1 continuously → in_ready drops after 16 accepts. ovf_err rises on the first refused cycle and stays high. The written data (wr_addr sequence) is unaffected.
- Bank release: with both banks full, in_ready rises exactly 1 cycle after the edge of bank 0's 16th read.
- Mid-frame reset: assert rst after 3 accepts → all outputs return to reset values asynchronously. After release, no rd_en occurs until 8 new accepts.
- Natural order (REORDER_BITREV_EN undefined): single frame gives (rd_lane, rd_addr) = (0,0),(1,0),(0,1),(1,1)…(1,7).

Source files
------------

// File: rtl/reorder_pkg.sv
// Shared types and helpers for the FFT output reorder controller.
package reorder_pkg;

    localparam int unsigned DEFAULT_FFT_LENGTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_FFT_LENGTH);
    localparam int unsigned LANE_ADDR_WIDTH    = DEFAULT_ADDR_WIDTH - 1;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // Reverses the low 'width' bits of value; higher bits are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[i] = value[width - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_ctrl_if.sv
// Control bus between the reorder controller, the upstream butterfly and the reorder memory.
interface reorder_ctrl_if
    import reorder_pkg::*;
#(
    parameter int unsigned LANE_AW = LANE_ADDR_WIDTH
);
    logic               in_valid;
    logic               in_ready;
    logic               wr_en;
    logic               wr_bank;
    logic [LANE_AW-1:0] wr_addr;
    logic               rd_en;
    logic               rd_bank;
    logic               rd_lane;
    logic [LANE_AW-1:0] rd_addr;
    logic               out_valid;
    logic               out_last;
    logic               ovf_err;

    modport master (
        output in_valid,
        input  in_ready, wr_en, wr_bank, wr_addr,
        input  rd_en, rd_bank, rd_lane, rd_addr,
        input  out_valid, out_last, ovf_err
    );

    modport slave (
        input  in_valid,
        output in_ready, wr_en, wr_bank, wr_addr,
        output rd_en, rd_bank, rd_lane, rd_addr,
        output out_valid, out_last, ovf_err
    );
endinterface

// File: rtl/reorder_rd_seq.sv
// Read sequencer: frame sample counter, order mapping and lane/address split.
// REORDER_BITREV_EN selects bit-reversed read order; otherwise natural order.
module reorder_rd_seq
    import reorder_pkg::*;
#(
    parameter int unsigned FFT_LENGTH = DEFAULT_FFT_LENGTH,
    parameter int unsigned ADDR_WIDTH = $clog2(FFT_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  done,
    output logic                  rd_lane,
    output logic [ADDR_WIDTH-2:0] rd_addr
);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(FFT_LENGTH - 1);

    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0] sample_idx;

    always_comb begin
        done     = en && (rd_cnt_q == CNT_LAST);
        rd_cnt_d = rd_cnt_q;
        if (en) begin
            rd_cnt_d = done ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
        end
`ifdef REORDER_BITREV_EN
        sample_idx = ADDR_WIDTH'(bitrev(32'(rd_cnt_q), ADDR_WIDTH));
`else
        sample_idx = rd_cnt_q;
`endif
        rd_lane = sample_idx[0];
        rd_addr = sample_idx[ADDR_WIDTH-1:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: rtl/reorder_ctrl.sv
// Ping-pong bank scheduler for the FFT output reorder memory (pair writes, serial reads).
// Read order is bit-reversed when REORDER_BITREV_EN is defined, natural otherwise.
module reorder_ctrl
    import reorder_pkg::*;
#(
    parameter int unsigned FFT_LENGTH = DEFAULT_FFT_LENGTH,
    parameter int unsigned ADDR_WIDTH = $clog2(FFT_LENGTH)
) (
    input  logic           clk,
    input  logic           rst,
    reorder_ctrl_if.slave  bus
);
    localparam int unsigned         LAW     = ADDR_WIDTH - 1;
    localparam logic [LAW-1:0]      WR_LAST = LAW'(FFT_LENGTH / 2 - 1);

    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, wr_bank_d;
    logic [LAW-1:0] wr_cnt_q, wr_cnt_d;
    logic           rd_bank_q, rd_bank_d;
    rd_state_e      state_q, state_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;

    logic           in_ready;
    logic           wr_en;
    logic           rd_en;
    logic           rd_done;
    logic           rd_lane;
    logic [LAW-1:0] rd_addr;

    reorder_rd_seq #(
        .FFT_LENGTH (FFT_LENGTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_seq (
        .clk     (clk),
        .rst     (rst),
        .en      (rd_en),
        .done    (rd_done),
        .rd_lane (rd_lane),
        .rd_addr (rd_addr)
    );

    // Reading starts in the same cycle the bank shows full, so IDLE can issue read 0.
    always_comb begin
        rd_en = (state_q == READ) || full_q[rd_bank_q];
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) state_d = READ;
            end
            READ: begin
                if (rd_done) begin
                    rd_bank_d = !rd_bank_q;
                    state_d   = full_q[!rd_bank_q] ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = !full_q[wr_bank_q];
        wr_en       = bus.in_valid && in_ready;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        if (wr_en) begin
            if (wr_cnt_q == WR_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_cnt_d          = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + LAW'(1);
            end
        end
        // Set and clear always hit different banks, so ordering here is irrelevant.
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        ovf_d       = ovf_q || (bus.in_valid && !in_ready);
        out_valid_d = rd_en;
        out_last_d  = rd_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            state_q     <= IDLE;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            state_q     <= state_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.wr_addr   = wr_cnt_q;
    assign bus.rd_en     = rd_en;
    assign bus.rd_bank   = rd_bank_q;
    assign bus.rd_lane   = rd_lane;
    assign bus.rd_addr   = rd_addr;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_reorder_ctrl.sv
// Directed self-checking bench for reorder_ctrl with N=16 (either read order via REORDER_BITREV_EN).
module tb_reorder_ctrl;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reorder_ctrl_if #(.LANE_AW(3)) bus ();

    reorder_ctrl #(
        .FFT_LENGTH (N),
        .ADDR_WIDTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [2:0] rev_addr [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    function automatic logic exp_lane(int i);
`ifdef REORDER_BITREV_EN
        return 1'((i % N) / 8);
`else
        return 1'((i % N) % 2);
`endif
    endfunction

    function automatic logic [2:0] exp_addr(int i);
`ifdef REORDER_BITREV_EN
        return rev_addr[(i % N) % 8];
`else
        return 3'((i % N) / 2);
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.wr_bank !== 1'b0) begin failures++; $display("FAIL reset_wr_bank got=%b exp=0", bus.wr_bank); end
        checks++; if (bus.wr_addr !== 3'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
        checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.rd_bank !== 1'b0) begin failures++; $display("FAIL reset_rd_bank got=%b exp=0", bus.rd_bank); end
        checks++; if (bus.rd_lane !== 1'b0) begin failures++; $display("FAIL reset_rd_lane got=%b exp=0", bus.rd_lane); end
        checks++; if (bus.rd_addr !== 3'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", bus.rd_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf_err got=%b exp=0", bus.ovf_err); end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en k=%0d got=%b exp=1", k, bus.wr_en); end
            checks++; if (bus.wr_addr !== 3'(k)) begin failures++; $display("FAIL single_wr_addr k=%0d got=%0d exp=%0d", k, bus.wr_addr, k); end
            checks++; if (bus.wr_bank !== 1'b0) begin failures++; $display("FAIL single_wr_bank k=%0d got=%b exp=0", k, bus.wr_bank); end
            checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL single_early_rd_en k=%0d got=%b exp=0", k, bus.rd_en); end
        end
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++; if (bus.rd_en !== 1'b1) begin failures++; $display("FAIL single_rd_en i=%0d got=%b exp=1", i, bus.rd_en); end
            checks++; if (bus.rd_bank !== 1'b0) begin failures++; $display("FAIL single_rd_bank i=%0d got=%b exp=0", i, bus.rd_bank); end
            checks++; if (bus.rd_lane !== exp_lane(i)) begin failures++; $display("FAIL single_rd_lane i=%0d got=%b exp=%b", i, bus.rd_lane, exp_lane(i)); end
            checks++; if (bus.rd_addr !== exp_addr(i)) begin failures++; $display("FAIL single_rd_addr i=%0d got=%0d exp=%0d", i, bus.rd_addr, exp_addr(i)); end
            checks++; if (bus.out_valid !== (i != 0)) begin failures++; $display("FAIL single_out_valid i=%0d got=%b exp=%b", i, bus.out_valid, (i != 0)); end
            checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL single_out_last_early i=%0d got=%b exp=0", i, bus.out_last); end
        end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL single_rd_en_end got=%b exp=0", bus.rd_en); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid_16 got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b1) begin failures++; $display("FAIL single_out_last got=%b exp=1", bus.out_last); end
        checks++; if (bus.wr_bank !== 1'b1) begin failures++; $display("FAIL single_wr_bank_after got=%b exp=1", bus.wr_bank); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_out_valid_after got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL single_out_last_after got=%b exp=0", bus.out_last); end
    endtask

    // Bank 0 fills in cycles 0..7, bank 1 in 8..15; reads run 8..39 with bank 1 from 24.
    task automatic test_back_to_back();
        logic e_rd, e_ready, e_ov, e_ol;
        do_reset();
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            bus.in_valid = (c < 16);
            #1;
            e_rd    = (c >= 8) && (c <= 39);
            e_ready = !((c >= 16) && (c <= 23));
            e_ov    = (c >= 9) && (c <= 40);
            e_ol    = (c == 24) || (c == 40);
            checks++; if (bus.rd_en !== e_rd) begin failures++; $display("FAIL b2b_rd_en c=%0d got=%b exp=%b", c, bus.rd_en, e_rd); end
            checks++; if (bus.in_ready !== e_ready) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, e_ready); end
            checks++; if (bus.out_valid !== e_ov) begin failures++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, e_ov); end
            checks++; if (bus.out_last !== e_ol) begin failures++; $display("FAIL b2b_out_last c=%0d got=%b exp=%b", c, bus.out_last, e_ol); end
            if (e_rd) begin
                checks++; if (bus.rd_bank !== (c >= 24)) begin failures++; $display("FAIL b2b_rd_bank c=%0d got=%b exp=%b", c, bus.rd_bank, (c >= 24)); end
                checks++; if (bus.rd_lane !== exp_lane(c - 8)) begin failures++; $display("FAIL b2b_rd_lane c=%0d got=%b exp=%b", c, bus.rd_lane, exp_lane(c - 8)); end
                checks++; if (bus.rd_addr !== exp_addr(c - 8)) begin failures++; $display("FAIL b2b_rd_addr c=%0d got=%0d exp=%0d", c, bus.rd_addr, exp_addr(c - 8)); end
            end
            if (c < 16) begin
                checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL b2b_wr_en c=%0d got=%b exp=1", c, bus.wr_en); end
                checks++; if (bus.wr_addr !== 3'(c % 8)) begin failures++; $display("FAIL b2b_wr_addr c=%0d got=%0d exp=%0d", c, bus.wr_addr, c % 8); end
                checks++; if (bus.wr_bank !== 1'(c / 8)) begin failures++; $display("FAIL b2b_wr_bank c=%0d got=%b exp=%0d", c, bus.wr_bank, c / 8); end
            end
        end
        checks++; if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL b2b_ovf_err got=%b exp=0", bus.ovf_err); end
        bus.in_valid = 1'b0;
    endtask

    // in_valid held high: refusals in cycles 16..23, bank 0 released for cycle 24.
    task automatic test_overflow();
        logic       e_ready, e_ovf;
        logic [2:0] e_addr;
        logic       e_bank;
        do_reset();
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            e_ready = !((c >= 16) && (c <= 23));
            e_ovf   = (c >= 17);
            e_addr  = (c < 16) ? 3'(c % 8) : ((c >= 24) ? 3'(c - 24) : 3'd0);
            e_bank  = (c < 16) ? 1'(c / 8) : 1'b0;
            checks++; if (bus.in_ready !== e_ready) begin failures++; $display("FAIL ovf_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, e_ready); end
            checks++; if (bus.wr_en !== e_ready) begin failures++; $display("FAIL ovf_wr_en c=%0d got=%b exp=%b", c, bus.wr_en, e_ready); end
            checks++; if (bus.wr_addr !== e_addr) begin failures++; $display("FAIL ovf_wr_addr c=%0d got=%0d exp=%0d", c, bus.wr_addr, e_addr); end
            checks++; if (bus.wr_bank !== e_bank) begin failures++; $display("FAIL ovf_wr_bank c=%0d got=%b exp=%b", c, bus.wr_bank, e_bank); end
            checks++; if (bus.ovf_err !== e_ovf) begin failures++; $display("FAIL ovf_err c=%0d got=%b exp=%b", c, bus.ovf_err, e_ovf); end
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky got=%b exp=1", bus.ovf_err); end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.wr_addr !== 3'(c)) begin failures++; $display("FAIL mrst_wr_addr c=%0d got=%0d exp=%0d", c, bus.wr_addr, c); end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.wr_addr !== 3'd3) begin failures++; $display("FAIL mrst_pre_wr_addr got=%0d exp=3", bus.wr_addr); end
        rst = 1'b1;
        #1;
        checks++; if (bus.wr_addr !== 3'd0) begin failures++; $display("FAIL mrst_wr_addr_async got=%0d exp=0", bus.wr_addr); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.wr_bank !== 1'b0) begin failures++; $display("FAIL mrst_wr_bank got=%b exp=0", bus.wr_bank); end
        checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL mrst_rd_en got=%b exp=0", bus.rd_en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%b exp=0", bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL mrst_idle_rd_en c=%0d got=%b exp=0", c, bus.rd_en); end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            #1;
            checks++; if (bus.wr_addr !== 3'(k)) begin failures++; $display("FAIL mrst_new_wr_addr k=%0d got=%0d exp=%0d", k, bus.wr_addr, k); end
            checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL mrst_new_rd_en k=%0d got=%b exp=0", k, bus.rd_en); end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.rd_en !== 1'b1) begin failures++; $display("FAIL mrst_first_rd_en got=%b exp=1", bus.rd_en); end
        checks++; if (bus.rd_bank !== 1'b0) begin failures++; $display("FAIL mrst_rd_bank got=%b exp=0", bus.rd_bank); end
        checks++; if (bus.rd_addr !== exp_addr(0)) begin failures++; $display("FAIL mrst_rd_addr got=%0d exp=%0d", bus.rd_addr, exp_addr(0)); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
